// File: rtl/noc_serial_receiver.sv
// Serial NoC packet receiver: HEADER + N_FLITS payload flits (last is TAIL) -> {padding, packet}
// with a valid/ready handoff. Optional length checking and the err port via NOC_RX_LEN_CHECK_EN.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 16
`endif

module noc_serial_receiver #(
  parameter int unsigned PACKET_BITS  = 16,
  parameter int unsigned PADDING_BITS = 0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          down_enable,
  input  logic [`FLIT_DATA_WIDTH+1:0]                   down_flit,
  output logic                                          down_ack,
  output logic                                          down_rej,
  output logic                                          valid,
  input  logic                                          ready,
  output logic [PACKET_BITS-1:0]                        packet,
  output logic [((PADDING_BITS > 0) ? PADDING_BITS : 1)-1:0] padding
`ifdef NOC_RX_LEN_CHECK_EN
  ,
  output logic                                          err
`endif
);

  localparam int unsigned FDW     = `FLIT_DATA_WIDTH;
  localparam int unsigned N_FLITS = (PACKET_BITS + FDW - 1) / FDW;
  localparam int unsigned CW      = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
  localparam int unsigned PW      = (PADDING_BITS > 0) ? PADDING_BITS : 1;
  localparam logic [CW-1:0] LAST  = CW'(N_FLITS - 1);
`ifdef NOC_RX_LEN_CHECK_EN
  localparam bit LEN_CHECK = 1'b1;
`else
  localparam bit LEN_CHECK = 1'b0;
`endif

  // Flit layout: {type[1:0], payload[FDW-1:0]}
  typedef enum logic [1:0] {
    FLIT_IDLE   = 2'b00,
    FLIT_HEADER = 2'b01,
    FLIT_DATA   = 2'b10,
    FLIT_TAIL   = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECEIVING,
    S_FULL
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PACKET_BITS-1:0] pkt_q, pkt_d;
  logic [PW-1:0]          pad_q, pad_d;
  logic                   ack_c, rej_c, wr_c, frame_err;
  flit_type_e             ftype;
  logic [FDW-1:0]         payload;
  logic [PW-1:0]          hdr_pad;

  assign ftype   = flit_type_e'(down_flit[FDW+1:FDW]);
  assign payload = down_flit[FDW-1:0];
  assign hdr_pad = (PADDING_BITS > 0) ? payload[PW-1:0] : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pkt_d     = pkt_q;
    pad_d     = pad_q;
    ack_c     = 1'b0;
    rej_c     = 1'b0;
    wr_c      = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (down_enable && ftype == FLIT_HEADER) begin
          ack_c   = 1'b1;
          pad_d   = hdr_pad;
          cnt_d   = '0;
          state_d = S_RECEIVING;
        end
      end
      S_RECEIVING: begin
        if (down_enable) begin
          ack_c = 1'b1;
          case (ftype)
            FLIT_HEADER: begin
              pad_d = hdr_pad;
              cnt_d = '0;
            end
            FLIT_DATA: begin
              if (LEN_CHECK && cnt_q == LAST) begin
                frame_err = 1'b1;
              end else begin
                wr_c  = 1'b1;
                cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
              end
            end
            FLIT_TAIL: begin
              if (LEN_CHECK && cnt_q != LAST) begin
                frame_err = 1'b1;
              end else begin
                wr_c    = 1'b1;
                cnt_d   = '0;
                state_d = S_FULL;
              end
            end
            default: ;
          endcase
          if (frame_err) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_FULL: begin
        if (down_enable && ftype == FLIT_HEADER) rej_c = 1'b1;
        if (ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Slot cnt_q covers bits [cnt_q*FDW +: FDW]; bits at or above PACKET_BITS are dropped
    if (wr_c) begin
      for (int unsigned k = 0; k < N_FLITS; k++) begin
        for (int unsigned b = 0; b < FDW && (k * FDW + b) < PACKET_BITS; b++) begin
          if (cnt_q == CW'(k)) pkt_d[k*FDW+b] = payload[b];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pkt_q   <= '0;
      pad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      pad_q   <= pad_d;
    end
  end

`ifdef NOC_RX_LEN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= frame_err;
  end
  assign err = err_q;
`endif

  assign valid    = (state_q == S_FULL);
  assign packet   = pkt_q;
  assign padding  = pad_q;
  assign down_ack = rst_n & ack_c;
  assign down_rej = rst_n & rej_c;

endmodule

// File: tb/tb_noc_serial_receiver.sv
// Bench for noc_serial_receiver: directed scenarios plus randomized sender/consumer traffic,
// checked every cycle against a packet-level model of the receiver.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 16
`endif

module tb_noc_serial_receiver;

  localparam int FDW  = `FLIT_DATA_WIDTH;
  localparam int PB   = 32;
  localparam int PADB = 4;
  localparam int N    = (PB + FDW - 1) / FDW;
  localparam int NPKT = 150;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_HDR  = 2'b01;
  localparam logic [1:0] T_DATA = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [FDW+1:0]  flit;
  logic            ack, rej, valid, ready;
  logic [PB-1:0]   packet;
  logic [PADB-1:0] padding;
`ifdef NOC_RX_LEN_CHECK_EN
  logic            err;
`endif

  noc_serial_receiver #(.PACKET_BITS(PB), .PADDING_BITS(PADB)) dut (
    .clk(clk), .rst_n(rst_n),
    .down_enable(en), .down_flit(flit), .down_ack(ack), .down_rej(rej),
    .valid(valid), .ready(ready), .packet(packet), .padding(padding)
`ifdef NOC_RX_LEN_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int hs = 0;

  // Packet-level reference: holding a finished packet, collecting one, or waiting.
  bit              m_have, m_inpkt, m_err;
  int              m_n;
  logic [FDW-1:0]  m_slot [N];
  logic [PADB-1:0] m_pad;

  logic            s_ack, s_rej, s_valid, s_err, acc;
  logic [PB-1:0]   s_packet;
  logic [PADB-1:0] s_pad;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [PB-1:0] m_packet();
    logic [N*FDW-1:0] w;
    for (int k = 0; k < N; k++) w[k*FDW +: FDW] = m_slot[k];
    return w[PB-1:0];
  endfunction

  function automatic void model_reset();
    m_have = 0; m_inpkt = 0; m_err = 0; m_n = 0; m_pad = '0;
    for (int k = 0; k < N; k++) m_slot[k] = '0;
  endfunction

  function automatic void model_update();
    logic [1:0]     t;
    logic [FDW-1:0] pl;
    int             idx;
    t = flit[FDW+1:FDW];
    pl = flit[FDW-1:0];
    m_err = 0;
    if (m_have) begin
      if (ready) m_have = 0;
    end else if (!m_inpkt) begin
      if (en && t == T_HDR) begin
        m_inpkt = 1; m_n = 0; m_pad = pl[PADB-1:0];
      end
    end else if (en) begin
      idx = (m_n < N - 1) ? m_n : N - 1;
      if (t == T_HDR) begin
        m_n = 0; m_pad = pl[PADB-1:0];
      end else if (t == T_DATA) begin
`ifdef NOC_RX_LEN_CHECK_EN
        if (m_n >= N - 1) begin m_err = 1; m_inpkt = 0; end
        else begin m_slot[idx] = pl; m_n++; end
`else
        m_slot[idx] = pl; m_n++;
`endif
      end else if (t == T_TAIL) begin
        m_inpkt = 0;
`ifdef NOC_RX_LEN_CHECK_EN
        if (m_n != N - 1) m_err = 1;
        else begin m_slot[idx] = pl; m_have = 1; end
`else
        m_slot[idx] = pl; m_have = 1;
`endif
      end
    end
  endfunction

  task automatic cycle();
    logic [1:0] t;
    logic e_ack, e_rej;
    @(negedge clk);
    t = flit[FDW+1:FDW];
    e_ack = rst_n && en && (m_inpkt || (!m_have && t == T_HDR));
    e_rej = rst_n && en && m_have && t == T_HDR;
    s_ack = ack; s_rej = rej; s_valid = valid; s_packet = packet; s_pad = padding;
    chk("ack", 64'(ack), 64'(e_ack));
    chk("rej", 64'(rej), 64'(e_rej));
    chk("valid", 64'(valid), 64'(m_have));
    if (m_have) begin
      chk("packet", 64'(packet), 64'(m_packet()));
      chk("padding", 64'(padding), 64'(m_pad));
    end
`ifdef NOC_RX_LEN_CHECK_EN
    s_err = err;
    chk("err", 64'(err), 64'(m_err));
`else
    s_err = 1'b0;
`endif
    acc = e_ack;
    if (valid && ready) hs++;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update();
    #1;
  endtask

  task automatic drv(bit e, logic [1:0] t, logic [FDW-1:0] pl, bit r);
    en = e; flit = {t, pl}; ready = r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [FDW+1:0] q[$];
    int cyc, len;

    rst_n = 1'b0;
    drv(1, T_HDR, 16'h0003, 0);
    model_reset();
    #1;
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_packet", 64'(packet), 64'd0);
    chk("reset_padding", 64'(padding), 64'd0);
    repeat (3) cycle();
    rst_n = 1'b1;
    drv(0, T_IDLE, 0, 0);
    cycle();

    // Basic packet: 0xDEADBEEF with pad 3
    drv(1, T_HDR, 16'h0003, 0);  cycle(); chk("t1_hdr_ack", 64'(s_ack), 64'd1);
    drv(1, T_DATA, 16'hBEEF, 0); cycle(); chk("t1_data_ack", 64'(s_ack), 64'd1);
    drv(1, T_TAIL, 16'hDEAD, 0); cycle(); chk("t1_tail_ack", 64'(s_ack), 64'd1);
    chk("t1_valid_not_yet", 64'(s_valid), 64'd0);
    drv(0, T_IDLE, 0, 0); cycle();
    chk("t1_valid", 64'(s_valid), 64'd1);
    chk("t1_packet", 64'(s_packet), 64'hDEADBEEF);
    chk("t1_padding", 64'(s_pad), 64'd3);

    // Header while full is rejected, including the consume cycle
    drv(1, T_HDR, 16'h0005, 0);
    repeat (2) begin
      cycle();
      chk("t2_rej", 64'(s_rej), 64'd1);
      chk("t2_ack", 64'(s_ack), 64'd0);
    end
    drv(1, T_HDR, 16'h0005, 1); cycle();
    chk("t2_consume_rej", 64'(s_rej), 64'd1);
    chk("t2_consume_ack", 64'(s_ack), 64'd0);
    drv(1, T_HDR, 16'h0005, 0); cycle();
    chk("t2_retry_valid", 64'(s_valid), 64'd0);
    chk("t2_retry_ack", 64'(s_ack), 64'd1);

    // Enable gap between DATA and TAIL
    drv(1, T_DATA, 16'h1111, 0); cycle();
    drv(0, T_DATA, 16'h9999, 0);
    repeat (2) begin cycle(); chk("t4_gap_ack", 64'(s_ack), 64'd0); end
    drv(1, T_TAIL, 16'h2222, 0); cycle();
    drv(0, T_IDLE, 0, 0); cycle();
    chk("t4_packet", 64'(s_packet), 64'h22221111);
    chk("t4_padding", 64'(s_pad), 64'd5);
    drv(0, T_IDLE, 0, 1); cycle();

    // Asynchronous reset mid-packet
    drv(1, T_HDR, 16'h0007, 1);  cycle();
    drv(1, T_DATA, 16'hAAAA, 1); cycle();
    drv(1, T_HDR, 16'h0008, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(valid), 64'd0);
    chk("t5_rst_ack", 64'(ack), 64'd0);
    chk("t5_rst_rej", 64'(rej), 64'd0);
    chk("t5_rst_packet", 64'(packet), 64'd0);
    chk("t5_rst_padding", 64'(padding), 64'd0);
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    drv(1, T_HDR, 16'h0009, 0);  cycle();
    drv(1, T_DATA, 16'h1234, 0); cycle();
    drv(1, T_TAIL, 16'h5678, 0); cycle();
    drv(0, T_IDLE, 0, 0); cycle();
    chk("t5_packet", 64'(s_packet), 64'h56781234);
    chk("t5_padding", 64'(s_pad), 64'd9);
    drv(0, T_IDLE, 0, 1); cycle();

`ifdef NOC_RX_LEN_CHECK_EN
    // Short packet: TAIL with no DATA
    drv(1, T_HDR, 16'h0001, 0);  cycle();
    drv(1, T_TAIL, 16'h4242, 0); cycle(); chk("t6_tail_ack", 64'(s_ack), 64'd1);
    drv(0, T_IDLE, 0, 0); cycle();
    chk("t6_err", 64'(s_err), 64'd1);
    chk("t6_valid", 64'(s_valid), 64'd0);
    drv(1, T_HDR, 16'h0002, 0); cycle();
    chk("t6_err_one_cycle", 64'(s_err), 64'd0);
    chk("t6_idle_hdr_ack", 64'(s_ack), 64'd1);
    // Over-long packet: second DATA errors, trailing TAIL ignored
    drv(1, T_DATA, 16'h0101, 0); cycle();
    drv(1, T_DATA, 16'h0202, 0); cycle();
    drv(1, T_TAIL, 16'h0303, 0); cycle();
    chk("t6_long_err", 64'(s_err), 64'd1);
    chk("t6_long_tail_ack", 64'(s_ack), 64'd0);
    drv(0, T_IDLE, 0, 0); cycle();
    chk("t6_long_valid", 64'(s_valid), 64'd0);
`endif

    // Randomized traffic
    for (int p = 0; p < NPKT; p++) begin
`ifdef NOC_RX_LEN_CHECK_EN
      len = N;
`else
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N + 1)) : N;
`endif
      q.push_back({T_HDR, FDW'($urandom_range(0, 15))});
      for (int f = 0; f < len; f++)
        q.push_back({(f == len - 1) ? T_TAIL : T_DATA, FDW'($urandom)});
    end
    hs = 0;
    cyc = 0;
    while ((q.size() > 0 || m_have || m_inpkt) && cyc < 20000) begin
      if (q.size() > 0) begin
        en = ($urandom_range(0, 9) < 8);
        flit = q[0];
      end else begin
        en = 1'b0;
        flit = '0;
      end
      ready = (cyc < 1500) ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      if (acc) void'(q.pop_front());
      cyc++;
    end
    chk("rand_drain_timeout", 64'(cyc < 20000), 64'd1);
    chk("rand_packet_count", 64'(hs), 64'(NPKT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
